segment_frame_decoder: RTL and testbench

//   Receive-side counterpart of the seg display driver: watches the multiplexed
//   8-digit segment/select bus and reconstructs the 32-bit hex value being shown.

---
 rtl/segment_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_segment_frame_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/segment_frame_decoder.sv
// Monitors a multiplexed 8-digit seven-segment bus and rebuilds the 32-bit hex value.
// Each digit is settle-filtered, pattern-decoded and assembled into frames, with error and link flags.
module segment_frame_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  segment_output,
    input  logic [7:0]  segment_select,
    output logic [31:0] value_out,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [7:0]  digit_mask,
    output logic        link_active
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {WAIT_SEL, SETTLING, HELD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   settle_cnt, settle_cnt_n;
    logic [7:0]      sel_q, seg_q, prev_sel;
    logic [31:0]     shadow;
    logic            err_sticky;
    logic            frame_pend;
    logic [TW-1:0]   timeout_cnt;

    logic [7:0]      sel_n;
    logic            sel_valid, sel_changed, capture;
    logic [4:0]      decoded;
    logic            clear_frame, timeout_hit;
    logic [7:0]      mask_base, cap_bits;
    logic            err_base;

    // Returns {bad_pattern, nibble}; dp is not part of the pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 5'h00;  7'h79: decode = 5'h01;
            7'h24: decode = 5'h02;  7'h30: decode = 5'h03;
            7'h19: decode = 5'h04;  7'h12: decode = 5'h05;
            7'h02: decode = 5'h06;  7'h78: decode = 5'h07;
            7'h00: decode = 5'h08;  7'h10: decode = 5'h09;
            7'h08: decode = 5'h0A;  7'h03: decode = 5'h0B;
            7'h46: decode = 5'h0C;  7'h21: decode = 5'h0D;
            7'h06: decode = 5'h0E;  7'h0E: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign sel_n       = ~sel_q;
    assign sel_valid   = $onehot(sel_n);
    assign sel_changed = (sel_q != prev_sel);
    assign decoded     = decode(seg_q[6:0]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_n      = state;
        settle_cnt_n = settle_cnt;
        capture      = 1'b0;
        case (state)
            WAIT_SEL: begin
                if (sel_valid) begin
                    if (SETTLE_CYCLES == 1) begin
                        capture = 1'b1;
                        state_n = HELD;
                    end else begin
                        state_n      = SETTLING;
                        settle_cnt_n = CW'(1);
                    end
                end
            end
            SETTLING, HELD: begin
                if (!sel_valid) begin
                    state_n      = WAIT_SEL;
                    settle_cnt_n = '0;
                end else if (sel_changed) begin
                    if (SETTLE_CYCLES == 1) begin
                        capture = 1'b1;
                        state_n = HELD;
                    end else begin
                        state_n      = SETTLING;
                        settle_cnt_n = CW'(1);
                    end
                end else if (state == SETTLING) begin
                    settle_cnt_n = settle_cnt + CW'(1);
                    if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_n = HELD;
                    end
                end
            end
            default: begin
                state_n      = WAIT_SEL;
                settle_cnt_n = '0;
            end
        endcase
    end

    // A completed frame or a link timeout empties the frame in progress before this cycle's capture lands.
    assign timeout_hit = !frame_pend && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign clear_frame = frame_pend || timeout_hit;
    assign mask_base   = clear_frame ? 8'h00 : digit_mask;
    assign err_base    = clear_frame ? 1'b0 : err_sticky;
    assign cap_bits    = capture ? sel_n : 8'h00;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_q       <= 8'hFF;
            seg_q       <= 8'hFF;
            prev_sel    <= 8'hFF;
            state       <= WAIT_SEL;
            settle_cnt  <= '0;
            shadow      <= '0;
            err_sticky  <= 1'b0;
            frame_pend  <= 1'b0;
            timeout_cnt <= '0;
            value_out   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            digit_mask  <= '0;
            link_active <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
            sel_q      <= segment_select;
            seg_q      <= segment_output;
            prev_sel   <= sel_q;
            state      <= state_n;
            settle_cnt <= settle_cnt_n;

            for (int i = 0; i < 8; i++)
                if (cap_bits[i]) shadow[4*i +: 4] <= decoded[3:0];
            digit_mask  <= mask_base | cap_bits;
            err_sticky  <= err_base | (capture & decoded[4]);
            frame_pend  <= capture && ((mask_base | cap_bits) == 8'hFF);
            frame_valid <= frame_pend;

            if (frame_pend) begin
                value_out   <= shadow;
                frame_error <= err_sticky;
                link_active <= 1'b1;
                timeout_cnt <= '0;
            end else begin
                if (timeout_cnt != TW'(TIMEOUT_CYCLES))
                    timeout_cnt <= timeout_cnt + TW'(1);
                if (timeout_hit)
                    link_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_segment_frame_decoder.sv
// Directed bench for segment_frame_decoder: drives scanned digit patterns and compares against hand-derived values.
module tb_segment_frame_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  segment_output = 8'hFF;
    logic [7:0]  segment_select = 8'hFF;

    logic [31:0] value_out, to_value_out;
    logic        frame_valid, frame_error, link_active;
    logic        to_frame_valid, to_frame_error, to_link_active;
    logic [7:0]  digit_mask, to_digit_mask;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fv_count = 0;
    int to_fv_cyc = -1;
    int fv_before;

    segment_frame_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
        .clock(clock), .reset(reset),
        .segment_output(segment_output), .segment_select(segment_select),
        .value_out(value_out), .frame_valid(frame_valid), .frame_error(frame_error),
        .digit_mask(digit_mask), .link_active(link_active)
    );

    segment_frame_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_to (
        .clock(clock), .reset(reset),
        .segment_output(segment_output), .segment_select(segment_select),
        .value_out(to_value_out), .frame_valid(to_frame_valid), .frame_error(to_frame_error),
        .digit_mask(to_digit_mask), .link_active(to_link_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        #1;
        if (frame_valid) fv_count++;
        if (to_frame_valid) to_fv_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    // Holds one select/pattern across n rising edges.
    task automatic drive(input logic [7:0] sel, input logic [6:0] pat, input int n);
        @(negedge clock);
        segment_select = sel;
        segment_output = {1'b1, pat};
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic dwell(input int idx, input logic [3:0] nib, input int n);
        logic [7:0] s;
        s = 8'd1 << idx;
        drive(~s, seg_of(nib), n);
    endtask

    task automatic blank(input int n);
        drive(8'hFF, 7'h7F, n);
    endtask

    task automatic scan(input logic [31:0] v, input int n, input int bad_digit);
        logic [7:0] s;
        for (int i = 7; i >= 0; i--) begin
            if (i == bad_digit) begin
                s = 8'd1 << i;
                drive(~s, 7'h7F, n);
            end else begin
                dwell(i, v[4*i +: 4], n);
            end
        end
        blank(4);
    endtask

    task automatic pulse_reset();
        blank(1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] v;

        repeat (3) @(negedge clock);
        check("reset_value", value_out, 32'h0);
        check("reset_fv", {31'b0, frame_valid}, 32'h0);
        check("reset_fe", {31'b0, frame_error}, 32'h0);
        check("reset_mask", {24'b0, digit_mask}, 32'h0);
        check("reset_link", {31'b0, link_active}, 32'h0);
        reset = 1'b1;

        // Clean frame
        fv_before = fv_count;
        scan(32'h1234ABCD, 16, -1);
        check("basic_frames", fv_count - fv_before, 1);
        check("basic_value", value_out, 32'h1234ABCD);
        check("basic_fe", {31'b0, frame_error}, 32'h0);
        check("basic_link", {31'b0, link_active}, 32'h1);
        check("basic_mask", {24'b0, digit_mask}, 32'h0);

        // Too-short dwell on digit 3 is ignored
        v = 32'hFEDCBA98;
        fv_before = fv_count;
        dwell(7, v[31:28], 16);
        dwell(3, v[15:12], 3);
        dwell(2, v[11:8], 16);
        check("short_mask", {24'b0, digit_mask}, 32'h84);
        dwell(6, v[27:24], 16);
        dwell(5, v[23:20], 16);
        dwell(4, v[19:16], 16);
        dwell(3, v[15:12], 16);
        dwell(1, v[7:4], 16);
        dwell(0, v[3:0], 16);
        blank(4);
        check("short_frames", fv_count - fv_before, 1);
        check("short_value", value_out, 32'hFEDCBA98);

        // Undecodable pattern on digit 5, then a clean frame
        fv_before = fv_count;
        scan(32'h89ABCDEF, 16, 5);
        check("err_frames", fv_count - fv_before, 1);
        check("err_value", value_out, 32'h890BCDEF);
        check("err_fe", {31'b0, frame_error}, 32'h1);
        scan(32'h0F1E2D3C, 16, -1);
        check("clean_value", value_out, 32'h0F1E2D3C);
        check("clean_fe", {31'b0, frame_error}, 32'h0);

        // Two digits selected at once is not a valid dwell
        v = 32'hC0FFEE12;
        fv_before = fv_count;
        dwell(7, v[31:28], 16);
        dwell(6, v[27:24], 16);
        drive(8'hFC, seg_of(4'h7), 20);
        check("multi_mask", {24'b0, digit_mask}, 32'hC0);
        check("multi_value_held", value_out, 32'h0F1E2D3C);
        for (int i = 5; i >= 0; i--) dwell(i, v[4*i +: 4], 16);
        blank(4);
        check("multi_frames", fv_count - fv_before, 1);
        check("multi_value", value_out, 32'hC0FFEE12);

        // Reset in the middle of a frame
        for (int i = 7; i >= 2; i--) dwell(i, 4'h5, 16);
        check("pre_reset_mask", {24'b0, digit_mask}, 32'hFC);
        fv_before = fv_count;
        pulse_reset();
        check("midrst_value", value_out, 32'h0);
        check("midrst_fe", {31'b0, frame_error}, 32'h0);
        check("midrst_mask", {24'b0, digit_mask}, 32'h0);
        check("midrst_link", {31'b0, link_active}, 32'h0);
        check("midrst_frames", fv_count - fv_before, 0);
        scan(32'h13579BDF, 16, -1);
        check("post_rst_frames", fv_count - fv_before, 1);
        check("post_rst_value", value_out, 32'h13579BDF);

        // Scan stops after one frame; the 64-cycle instance drops its link
        pulse_reset();
        to_fv_cyc = -1;
        scan(32'h2468ACE0, 6, -1);
        check("to_value", to_value_out, 32'h2468ACE0);
        check("to_link_up", {31'b0, to_link_active}, 32'h1);
        if (to_fv_cyc < 0) begin
            check("to_frame_seen", 32'h0, 32'h1);
        end else begin
            while (cyc < to_fv_cyc + 63) @(negedge clock);
            check("to_link_before", {31'b0, to_link_active}, 32'h1);
            @(negedge clock);
            check("to_link_drop", {31'b0, to_link_active}, 32'h0);
            check("to_value_held", to_value_out, 32'h2468ACE0);
            check("to_mask", {24'b0, to_digit_mask}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
